// File: rtl/umi_txn_monitor_if.sv
// Observation bundle for N UMI host request/response port pairs; the monitor
// only ever sees these through the slave modport.
interface umi_txn_monitor_if #(
  parameter int N  = 1,
  parameter int CW = 32
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*CW-1:0] req_cmd;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [N*CW-1:0] resp_cmd;

  modport master (
    output req_valid, req_ready, req_cmd,
    output resp_valid, resp_ready, resp_cmd
  );

  modport slave (
    input req_valid, req_ready, req_cmd,
    input resp_valid, resp_ready, resp_cmd
  );
endinterface

// File: rtl/umi_txn_monitor.sv
// Passive N-channel UMI transaction monitor: beat counters, outstanding tracking,
// watchdog and underflow flags. Define UMI_TXN_MONITOR_HWM_EN for high-water marks.
module umi_txn_monitor #(
  parameter int N       = 1,
  parameter int CW      = 32,
  parameter int CNTW    = 32,
  parameter int OSW     = 8,
  parameter int TIMEOUT = 4096,
  localparam int SELW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            clear,
  umi_txn_monitor_if.slave bus,
  input  logic [SELW-1:0] rd_sel,
  output logic [CNTW-1:0] rd_req_cnt,
  output logic [CNTW-1:0] rd_resp_cnt,
  output logic [OSW-1:0]  rd_outst,
  output logic [OSW-1:0]  rd_hwm,
  output logic [N-1:0]    timeout,
  output logic [N-1:0]    underflow,
  output logic            idle
);

  localparam logic [OSW-1:0] OS_MAX = '1;

  logic [N-1:0]    req_beat;
  logic [N-1:0]    resp_beat;
  logic [N-1:0]    exp_req;
  logic [N-1:0]    cmpl_resp;
  logic [N-1:0]    uflow_set;
  logic            idle_nxt;
  logic [OSW-1:0]  outst     [N];
  logic [OSW-1:0]  outst_nxt [N];
  logic [CNTW-1:0] req_cnt   [N];
  logic [CNTW-1:0] resp_cnt  [N];
  logic [31:0]     sel_ext;
  logic            unused_cmd_bits;

  assign sel_ext         = 32'(rd_sel);
  assign unused_cmd_bits = ^{bus.req_cmd, bus.resp_cmd};

  // Posted writes never get a response, so they are excluded from outstanding.
  always_comb begin
    idle_nxt = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_beat[i]  = bus.req_valid[i] & bus.req_ready[i];
      resp_beat[i] = bus.resp_valid[i] & bus.resp_ready[i];
      exp_req[i]   = req_beat[i] && (bus.req_cmd[i*CW +: 5] != 5'h05);
      cmpl_resp[i] = resp_beat[i] && bus.resp_cmd[i*CW + 22];
      uflow_set[i] = cmpl_resp[i] && !exp_req[i] && (outst[i] == '0);
      outst_nxt[i] = outst[i];
      if (exp_req[i] && !cmpl_resp[i] && (outst[i] != OS_MAX))
        outst_nxt[i] = outst[i] + 1'b1;
      else if (cmpl_resp[i] && !exp_req[i] && (outst[i] != '0))
        outst_nxt[i] = outst[i] - 1'b1;
      if (outst_nxt[i] != '0)
        idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      for (int i = 0; i < N; i++) begin
        req_cnt[i]  <= '0;
        resp_cnt[i] <= '0;
        outst[i]    <= '0;
      end
      underflow <= '0;
      idle      <= 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_beat[i])
          req_cnt[i] <= req_cnt[i] + 1'b1;
        if (resp_beat[i])
          resp_cnt[i] <= resp_cnt[i] + 1'b1;
        outst[i] <= outst_nxt[i];
        if (uflow_set[i])
          underflow[i] <= 1'b1;
      end
      idle <= idle_nxt;
    end
  end

`ifdef UMI_TXN_MONITOR_HWM_EN
  logic [OSW-1:0] hwm [N];

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      for (int i = 0; i < N; i++)
        hwm[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (outst_nxt[i] > hwm[i])
          hwm[i] <= outst_nxt[i];
    end
  end
`endif

  // The watchdog stops counting once it hits TIMEOUT-1; the flag stays until reset/clear.
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WDW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
      localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

      logic [WDW-1:0] wd [N];
      logic [N-1:0]   timeout_q;

      always_ff @(posedge clk) begin
        if (!nreset || clear) begin
          for (int i = 0; i < N; i++)
            wd[i] <= '0;
          timeout_q <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if ((outst[i] == '0) || cmpl_resp[i]) begin
              wd[i] <= '0;
            end else if (wd[i] != WD_LAST) begin
              wd[i] <= wd[i] + 1'b1;
              if ((wd[i] + 1'b1) == WD_LAST)
                timeout_q[i] <= 1'b1;
            end else begin
              timeout_q[i] <= 1'b1;
            end
          end
        end
      end

      assign timeout = timeout_q;
    end else begin : g_nowd
      assign timeout = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      rd_req_cnt  <= '0;
      rd_resp_cnt <= '0;
      rd_outst    <= '0;
      rd_hwm      <= '0;
    end else if (sel_ext < 32'(N)) begin
      rd_req_cnt  <= req_cnt[rd_sel];
      rd_resp_cnt <= resp_cnt[rd_sel];
      rd_outst    <= outst[rd_sel];
`ifdef UMI_TXN_MONITOR_HWM_EN
      rd_hwm      <= hwm[rd_sel];
`else
      rd_hwm      <= '0;
`endif
    end else begin
      rd_req_cnt  <= '0;
      rd_resp_cnt <= '0;
      rd_outst    <= '0;
      rd_hwm      <= '0;
    end
  end

endmodule

// File: tb/tb_umi_txn_monitor.sv
// Directed self-checking bench for umi_txn_monitor (N=2, 4-bit counters,
// 3-bit outstanding, TIMEOUT=16); hwm expectations follow UMI_TXN_MONITOR_HWM_EN.
module tb_umi_txn_monitor;

  localparam int N       = 2;
  localparam int CW      = 32;
  localparam int CNTW    = 4;
  localparam int OSW     = 3;
  localparam int TIMEOUT = 16;
  localparam int SELW    = 1;

`ifdef UMI_TXN_MONITOR_HWM_EN
  localparam bit HWM_ON = 1'b1;
`else
  localparam bit HWM_ON = 1'b0;
`endif

  localparam logic [31:0] RD    = 32'h0000_0001;
  localparam logic [31:0] PW    = 32'h0000_0005;
  localparam logic [31:0] EOM   = 32'h0040_0000;
  localparam logic [31:0] NOEOM = 32'h0000_0002;

  logic            clk = 1'b0;
  logic            nreset;
  logic            clear;
  logic [SELW-1:0] rd_sel;
  logic [CNTW-1:0] rd_req_cnt;
  logic [CNTW-1:0] rd_resp_cnt;
  logic [OSW-1:0]  rd_outst;
  logic [OSW-1:0]  rd_hwm;
  logic [N-1:0]    timeout;
  logic [N-1:0]    underflow;
  logic            idle;

  int total = 0;
  int bad   = 0;

  umi_txn_monitor_if #(.N(N), .CW(CW)) bus ();

  umi_txn_monitor #(
    .N(N), .CW(CW), .CNTW(CNTW), .OSW(OSW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .clear(clear),
    .bus(bus),
    .rd_sel(rd_sel),
    .rd_req_cnt(rd_req_cnt),
    .rd_resp_cnt(rd_resp_cnt),
    .rd_outst(rd_outst),
    .rd_hwm(rd_hwm),
    .timeout(timeout),
    .underflow(underflow),
    .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hwmExp(input logic [31:0] v);
    return HWM_ON ? v : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of beats from a negedge and returns at the following negedge.
  task automatic applyStimulus(input logic [1:0] rv, input logic [1:0] rrdy,
                               input logic [31:0] rc0, input logic [31:0] rc1,
                               input logic [1:0] sv, input logic [31:0] sc0,
                               input logic [31:0] sc1);
    bus.req_valid  = rv;
    bus.req_ready  = rrdy;
    bus.req_cmd    = {rc1, rc0};
    bus.resp_valid = sv;
    bus.resp_ready = 2'b11;
    bus.resp_cmd   = {sc1, sc0};
    @(negedge clk);
    bus.req_valid  = 2'b00;
    bus.resp_valid = 2'b00;
  endtask

  task automatic readChannel(input logic [SELW-1:0] sel);
    rd_sel = sel;
    @(negedge clk);
  endtask

  initial begin
    nreset         = 1'b0;
    clear          = 1'b0;
    rd_sel         = '0;
    bus.req_valid  = '0;
    bus.req_ready  = '1;
    bus.req_cmd    = '0;
    bus.resp_valid = '0;
    bus.resp_ready = '1;
    bus.resp_cmd   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_req_cnt", 32'(rd_req_cnt), 32'd0);
    checkOutput("rst_outst", 32'(rd_outst), 32'd0);
    checkOutput("rst_flags", {28'd0, timeout, underflow}, 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // ch0: three reads, plus one valid-without-ready that must not count
    repeat (3) applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    checkOutput("reads_idle", 32'(idle), 32'd0);
    applyStimulus(2'b01, 2'b00, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    readChannel(1'b0);
    checkOutput("reads_req_cnt", 32'(rd_req_cnt), 32'd3);
    checkOutput("reads_outst", 32'(rd_outst), 32'd3);
    checkOutput("reads_hwm", 32'(rd_hwm), hwmExp(32'd3));

    repeat (3) applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 2'b01, EOM, 32'd0);
    checkOutput("resps_idle", 32'(idle), 32'd1);
    readChannel(1'b0);
    checkOutput("resps_resp_cnt", 32'(rd_resp_cnt), 32'd3);
    checkOutput("resps_outst", 32'(rd_outst), 32'd0);
    checkOutput("resps_hwm", 32'(rd_hwm), hwmExp(32'd3));
    checkOutput("resps_underflow", 32'(underflow), 32'd0);

    // non-EOM response at zero outstanding is counted but is not an underflow
    applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 2'b01, NOEOM, 32'd0);
    checkOutput("noeom_underflow", 32'(underflow), 32'd0);
    readChannel(1'b0);
    checkOutput("noeom_resp_cnt", 32'(rd_resp_cnt), 32'd4);

    // ch1: posted writes never become outstanding
    repeat (4) applyStimulus(2'b10, 2'b11, 32'd0, PW, 2'b00, 32'd0, 32'd0);
    checkOutput("pw_idle", 32'(idle), 32'd1);
    readChannel(1'b1);
    checkOutput("pw_req_cnt", 32'(rd_req_cnt), 32'd4);
    checkOutput("pw_outst", 32'(rd_outst), 32'd0);
    repeat (13) applyStimulus(2'b10, 2'b11, 32'd0, PW, 2'b00, 32'd0, 32'd0);
    readChannel(1'b1);
    checkOutput("wrap_req_cnt", 32'(rd_req_cnt), 32'd1);

    applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 2'b10, 32'd0, EOM);
    checkOutput("uflow_ch1", 32'(underflow), 32'd2);
    readChannel(1'b1);
    checkOutput("uflow_outst", 32'(rd_outst), 32'd0);
    checkOutput("uflow_resp_cnt", 32'(rd_resp_cnt), 32'd1);

    // ch0: same-cycle request and completion leaves outstanding unchanged
    applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b01, EOM, 32'd0);
    checkOutput("same_underflow", 32'(underflow), 32'd2);
    readChannel(1'b0);
    checkOutput("same_outst", 32'(rd_outst), 32'd1);
    checkOutput("same_req_cnt", 32'(rd_req_cnt), 32'd5);
    checkOutput("same_resp_cnt", 32'(rd_resp_cnt), 32'd5);
    applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 2'b01, EOM, 32'd0);
    checkOutput("same_idle", 32'(idle), 32'd1);

    // watchdog: completion on stall cycle 15 avoids the flag
    applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    repeat (14) @(negedge clk);
    applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 2'b01, EOM, 32'd0);
    checkOutput("wd_resp15", 32'(timeout), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("wd_idle_long", 32'(timeout), 32'd0);

    applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    repeat (14) @(negedge clk);
    checkOutput("wd_stall14", 32'(timeout), 32'd0);
    @(negedge clk);
    checkOutput("wd_stall15", 32'(timeout), 32'd1);
    readChannel(1'b0);
    checkOutput("wd_req_cnt", 32'(rd_req_cnt), 32'd7);
    checkOutput("wd_resp_cnt", 32'(rd_resp_cnt), 32'd7);
    checkOutput("wd_outst", 32'(rd_outst), 32'd1);
    checkOutput("wd_sticky", 32'(timeout), 32'd1);

    // ch1: outstanding saturates at 7
    repeat (8) applyStimulus(2'b10, 2'b11, 32'd0, RD, 2'b00, 32'd0, 32'd0);
    readChannel(1'b1);
    checkOutput("sat_outst", 32'(rd_outst), 32'd7);
    checkOutput("sat_req_cnt", 32'(rd_req_cnt), 32'd9);
    checkOutput("sat_hwm", 32'(rd_hwm), hwmExp(32'd7));
    checkOutput("sat_timeout", 32'(timeout), 32'd1);

    // clear with a same-cycle beat: everything zero, beat dropped
    clear = 1'b1;
    applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    clear = 1'b0;
    checkOutput("clr_flags", {28'd0, timeout, underflow}, 32'd0);
    checkOutput("clr_idle", 32'(idle), 32'd1);
    readChannel(1'b0);
    checkOutput("clr_ch0_req_cnt", 32'(rd_req_cnt), 32'd0);
    checkOutput("clr_ch0_outst", 32'(rd_outst), 32'd0);
    checkOutput("clr_ch0_hwm", 32'(rd_hwm), 32'd0);
    readChannel(1'b1);
    checkOutput("clr_ch1_req_cnt", 32'(rd_req_cnt), 32'd0);
    checkOutput("clr_ch1_outst", 32'(rd_outst), 32'd0);

    // reset mid-transaction: the late response becomes an underflow
    applyStimulus(2'b01, 2'b11, RD, 32'd0, 2'b00, 32'd0, 32'd0);
    checkOutput("mid_idle_busy", 32'(idle), 32'd0);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    checkOutput("mid_idle_rst", 32'(idle), 32'd1);
    applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 2'b01, EOM, 32'd0);
    checkOutput("mid_underflow", 32'(underflow), 32'd1);
    readChannel(1'b0);
    checkOutput("mid_req_cnt", 32'(rd_req_cnt), 32'd0);
    checkOutput("mid_resp_cnt", 32'(rd_resp_cnt), 32'd1);
    checkOutput("mid_outst", 32'(rd_outst), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
